// File: rtl/mul8_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mul8_seq_ctrl_if
//   Bundles the control-side handshake (Start/A/B in, Busy/Done/P out) and the
//   shared 4x4 multiplier link (MA/MB out, MP in) of mul8_seq_ctrl.
//
//   Signals:
//     Start  1   operation request, sampled only while Busy is low
//     A, B   8   unsigned operands, sampled with an accepted Start
//     Busy   1   multiplication in progress
//     Done   1   one-cycle pulse, P carries a fresh product
//     P      16  product, held until the next completion
//     MA, MB 4   nibble operands presented to the shared multiplier
//     MP     8   product returned by the shared multiplier
//
//   Modports:
//     slave  - the sequencing controller itself
//     master - the surrounding logic (switch/control side plus the multiplier)
// ---------------------------------------------------------------------------
interface mul8_seq_ctrl_if;
  logic        Start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        Busy;
  logic        Done;
  logic [15:0] P;
  logic [3:0]  MA;
  logic [3:0]  MB;
  logic [7:0]  MP;

  modport slave (
    input  Start, A, B, MP,
    output Busy, Done, P, MA, MB
  );

  modport master (
    output Start, A, B, MP,
    input  Busy, Done, P, MA, MB
  );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul8_seq_ctrl
//   Computes an unsigned 8x8 -> 16-bit product by time-sharing an external
//   4x4 -> 8-bit multiplier over four nibble steps. Operands are latched on an
//   accepted Start, each nibble pair is driven to the shared multiplier for
//   MP_LATENCY+1 cycles, the returned partial products are shifted and summed,
//   and the result is presented on P together with a one-cycle Done pulse.
//
//   Parameters:
//     MP_LATENCY  cycles from an MA/MB change to a valid MP (legal 0..3)
//
//   Ports:
//     Clock   in   rising-edge clock
//     Resetn  in   asynchronous active-low reset
//     bus     slave view of mul8_seq_ctrl_if (Start/A/B/MP in,
//             Busy/Done/P/MA/MB out); all outputs are driven from flops
// ---------------------------------------------------------------------------
module mul8_seq_ctrl #(
  parameter int MP_LATENCY = 0
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  mul8_seq_ctrl_if.slave        bus
);

  // Last value of the per-step wait counter; the step's partial product is
  // taken on this cycle.
  localparam logic [1:0] LAT_LAST = 2'(MP_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_STEP = 2'b01
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  ar_q, ar_d;
  logic [7:0]  br_q, br_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  step_q, step_d;
  logic [1:0]  wait_q, wait_d;
  logic [15:0] p_q, p_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [3:0]  ma_q, ma_d;
  logic [3:0]  mb_q, mb_d;
  logic [15:0] sum_s;

  // Nibble pair for a step: step bit 0 selects the A nibble, bit 1 the B
  // nibble, giving lo/lo, hi/lo, lo/hi, hi/hi.
  function automatic logic [7:0] sel_nibbles(
    input logic [7:0] ar,
    input logic [7:0] br,
    input logic [1:0] step
  );
    logic [3:0] ma;
    logic [3:0] mb;
    ma = step[0] ? ar[7:4] : ar[3:0];
    mb = step[1] ? br[7:4] : br[3:0];
    return {ma, mb};
  endfunction

  // Places an 8-bit partial product at its weight within the 16-bit sum.
  function automatic logic [15:0] align_pp(
    input logic [7:0] mp,
    input logic [1:0] step
  );
    logic [15:0] pp;
    case (step)
      2'd0:    pp = {8'h00, mp};
      2'd1:    pp = {4'h0, mp, 4'h0};
      2'd2:    pp = {4'h0, mp, 4'h0};
      2'd3:    pp = {mp, 8'h00};
      default: pp = 16'h0000;
    endcase
    return pp;
  endfunction

  // Next-state, datapath and output decode for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    br_d    = br_q;
    acc_d   = acc_q;
    step_d  = step_q;
    wait_d  = wait_q;
    p_d     = p_q;
    done_d  = 1'b0;
    ma_d    = ma_q;
    mb_d    = mb_q;
    // No carry-out: the largest possible product (16'hFE01) fits in 16 bits.
    sum_s   = acc_q + align_pp(bus.MP, step_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          ar_d         = bus.A;
          br_d         = bus.B;
          acc_d        = 16'h0000;
          step_d       = 2'd0;
          wait_d       = 2'd0;
          // Step 0 nibbles are registered now so they are already on MA/MB
          // in the first busy cycle.
          {ma_d, mb_d} = sel_nibbles(bus.A, bus.B, 2'd0);
          state_d      = ST_STEP;
        end else begin
          ma_d    = 4'h0;
          mb_d    = 4'h0;
          state_d = ST_IDLE;
        end
      end

      ST_STEP: begin
        if (wait_q == LAT_LAST) begin
          acc_d  = sum_s;
          wait_d = 2'd0;
          if (step_q == 2'd3) begin
            p_d     = sum_s;
            done_d  = 1'b1;
            step_d  = 2'd0;
            ma_d    = 4'h0;
            mb_d    = 4'h0;
            state_d = ST_IDLE;
          end else begin
            step_d       = step_q + 2'd1;
            {ma_d, mb_d} = sel_nibbles(ar_q, br_q, step_q + 2'd1);
            state_d      = ST_STEP;
          end
        end else begin
          // MA/MB hold while the multiplier settles.
          wait_d = wait_q + 2'd1;
        end
      end

      default: begin
        // Unreachable encodings fall back to a clean idle controller.
        state_d = ST_IDLE;
        ar_d    = 8'h00;
        br_d    = 8'h00;
        acc_d   = 16'h0000;
        step_d  = 2'd0;
        wait_d  = 2'd0;
        done_d  = 1'b0;
        ma_d    = 4'h0;
        mb_d    = 4'h0;
      end
    endcase

    busy_d = (state_d == ST_STEP);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      ar_q    <= 8'h00;
      br_q    <= 8'h00;
      acc_q   <= 16'h0000;
      step_q  <= 2'd0;
      wait_q  <= 2'd0;
      p_q     <= 16'h0000;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ma_q    <= 4'h0;
      mb_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      br_q    <= br_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
      p_q     <= p_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.P    = p_q;
  assign bus.MA   = ma_q;
  assign bus.MB   = mb_q;

endmodule
